// File: rtl/cpu_sequencer_pkg.sv
// Shared encodings for the CPU sequencer: FSM states, opcodes and the
// datapath mux-select values the control unit drives.
package cpu_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_MEMRD, S_MEMWR, S_EXEC, S_HALT
  } state_t;

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_LDA  = 4'd1;
  localparam logic [3:0] OP_STA  = 4'd2;
  localparam logic [3:0] OP_MOVR = 4'd3;
  localparam logic [3:0] OP_MOVA = 4'd4;
  localparam logic [3:0] OP_ADD  = 4'd5;
  localparam logic [3:0] OP_SUB  = 4'd6;
  localparam logic [3:0] OP_ADDM = 4'd7;
  localparam logic [3:0] OP_HALT = 4'd8;

  localparam logic       ALU_ADD  = 1'b0;
  localparam logic       ALU_SUB  = 1'b1;
  localparam logic       U8_REG   = 1'b0;
  localparam logic       U8_MBR   = 1'b1;
  localparam logic [1:0] U9_MUX2  = 2'd0;
  localparam logic [1:0] U9_MBR   = 2'd1;
  localparam logic [1:0] U9_ALU   = 2'd2;

  // Everything above HALT is unassigned opcode space.
  function automatic logic is_illegal(input logic [3:0] op);
    return op > OP_HALT;
  endfunction

endpackage

// File: rtl/cpu_sequencer_if.sv
// Control bus between the sequencer and the datapath.
//   ir, mem_ack          : datapath -> sequencer (IR contents, RAM done)
//   read_rom..load_acc   : datapath strobes
//   load_reg_a..d        : register-file write enables
//   alu_sel, mux_sel_u7/u8/u9 : datapath selects
interface cpu_sequencer_if;
  import cpu_sequencer_pkg::*;

  logic [7:0] ir;
  logic       mem_ack;
  logic       read_rom, inc_pc, load_ir, load_mar;
  logic       read_ram, write_ram, load_mbr, load_acc;
  logic       load_reg_a, load_reg_b, load_reg_c, load_reg_d;
  logic       alu_sel;
  logic [1:0] mux_sel_u7;
  logic       mux_sel_u8;
  logic [1:0] mux_sel_u9;

  modport master (
    input  ir, mem_ack,
    output read_rom, inc_pc, load_ir, load_mar, read_ram, write_ram, load_mbr,
           load_acc, load_reg_a, load_reg_b, load_reg_c, load_reg_d,
           alu_sel, mux_sel_u7, mux_sel_u8, mux_sel_u9
  );

  modport slave (
    output ir, mem_ack,
    input  read_rom, inc_pc, load_ir, load_mar, read_ram, write_ram, load_mbr,
           load_acc, load_reg_a, load_reg_b, load_reg_c, load_reg_d,
           alu_sel, mux_sel_u7, mux_sel_u8, mux_sel_u9
  );
endinterface

// File: rtl/cpu_sequencer_instr_counter.sv
// Retired-instruction counter; wraps silently at 2^W.
//   clk, rst (async, active low), en (count this cycle), count
module instr_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] count
);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)    count <= '0;
    else if (en) count <= count + 1'b1;
  end
endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle CPU control unit: fetch/decode/memory/execute sequencing.
//   clk, rst (async, active low), run (level start/continue)
//   bus     : control bus (ir, mem_ack in; strobes and selects out)
//   busy    : executing an instruction (not IDLE / HALT)
//   halted  : HALT reached, only reset leaves it
//   illegal : one-cycle pulse when an unassigned opcode is decoded
//   retired : completed-instruction count (8-bit, wraps)
module cpu_sequencer
  import cpu_sequencer_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            run,
  cpu_sequencer_if.master bus,
  output logic            busy,
  output logic            halted,
  output logic            illegal,
  output logic [7:0]      retired
);
  state_t     state, state_nxt, done_st;
  logic [3:0] op;
  logic [1:0] rsel;
  logic [3:0] load_reg;
  logic       retire;
  logic       read_rom, inc_pc, load_ir, load_mar;
  logic       read_ram, write_ram, load_mbr, load_acc;
  logic       alu_sel, u8;
  logic [1:0] u7, u9;
  logic       unused_ir;

  assign op        = bus.ir[7:4];
  assign rsel      = bus.ir[1:0];
  assign unused_ir = ^bus.ir[3:2];

  // Once an instruction completes, run decides whether to keep going.
  assign done_st = run ? S_FETCH : S_IDLE;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    retire    = 1'b0;
    read_rom  = 1'b0; inc_pc    = 1'b0; load_ir  = 1'b0; load_mar = 1'b0;
    read_ram  = 1'b0; write_ram = 1'b0; load_mbr = 1'b0; load_acc = 1'b0;
    load_reg  = 4'b0000;
    alu_sel   = ALU_ADD;
    u7        = 2'd0;
    u8        = U8_REG;
    u9        = U9_MUX2;
    illegal   = 1'b0;
    halted    = 1'b0;
    busy      = 1'b1;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (run) state_nxt = S_FETCH;
      end
      S_FETCH: begin
        read_rom  = 1'b1;
        load_ir   = 1'b1;
        inc_pc    = 1'b1;
        state_nxt = S_DECODE;
      end
      S_DECODE: begin
        case (op)
          OP_LDA, OP_ADDM: begin load_mar = 1'b1; state_nxt = S_MEMRD; end
          OP_STA:          begin load_mar = 1'b1; state_nxt = S_MEMWR; end
          OP_MOVR, OP_MOVA, OP_ADD, OP_SUB: state_nxt = S_EXEC;
          OP_NOP:          begin retire = 1'b1; state_nxt = done_st; end
          OP_HALT:         state_nxt = S_HALT;
          default: begin
            illegal   = is_illegal(op);
            retire    = 1'b1;
            state_nxt = done_st;
          end
        endcase
      end
      S_MEMRD: begin
        read_ram = 1'b1;
        if (bus.mem_ack) begin
          load_mbr  = 1'b1;
          state_nxt = S_EXEC;
        end
      end
      S_MEMWR: begin
        write_ram = 1'b1;
        if (bus.mem_ack) begin
          retire    = 1'b1;
          state_nxt = done_st;
        end
      end
      S_EXEC: begin
        case (op)
          OP_LDA:  begin load_acc = 1'b1; u8 = U8_MBR; u9 = U9_MBR; end
          OP_ADDM: begin load_acc = 1'b1; u8 = U8_MBR; u9 = U9_ALU; end
          OP_MOVR: begin load_acc = 1'b1; u7 = rsel; end
          OP_MOVA: load_reg = 4'b0001 << rsel;
          OP_ADD, OP_SUB: begin
            load_acc = 1'b1;
            u7       = rsel;
            u9       = U9_ALU;
            alu_sel  = (op == OP_SUB) ? ALU_SUB : ALU_ADD;
          end
          default: ;
        endcase
        retire    = 1'b1;
        state_nxt = done_st;
      end
      S_HALT: begin
        busy   = 1'b0;
        halted = 1'b1;
      end
      default: begin
        busy      = 1'b0;
        state_nxt = S_IDLE;
      end
    endcase
  end

  assign bus.read_rom   = read_rom;
  assign bus.inc_pc     = inc_pc;
  assign bus.load_ir    = load_ir;
  assign bus.load_mar   = load_mar;
  assign bus.read_ram   = read_ram;
  assign bus.write_ram  = write_ram;
  assign bus.load_mbr   = load_mbr;
  assign bus.load_acc   = load_acc;
  assign bus.load_reg_a = load_reg[0];
  assign bus.load_reg_b = load_reg[1];
  assign bus.load_reg_c = load_reg[2];
  assign bus.load_reg_d = load_reg[3];
  assign bus.alu_sel    = alu_sel;
  assign bus.mux_sel_u7 = u7;
  assign bus.mux_sel_u8 = u8;
  assign bus.mux_sel_u9 = u9;

  instr_counter #(.W(8)) u_retired (
    .clk   (clk),
    .rst   (rst),
    .en    (retire),
    .count (retired)
  );
endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench for cpu_sequencer: instruction-level plan expanded into a per-cycle
// stimulus/expectation trace, replayed against the DUT.
module tb_cpu_sequencer;
  typedef struct packed {
    logic       read_rom, inc_pc, load_ir, load_mar;
    logic       read_ram, write_ram, load_mbr, load_acc;
    logic [3:0] load_reg;
    logic       alu_sel;
    logic [1:0] u7;
    logic       u8;
    logic [1:0] u9;
    logic       busy, halted, illegal;
    logic [7:0] retired;
  } outs_t;

  typedef struct packed {
    logic       rst, run;
    logic [7:0] ir;
    logic       ack;
  } stim_t;

  logic       clk = 1'b0, rst = 1'b0, run = 1'b0;
  logic       busy, halted, illegal;
  logic [7:0] retired;

  cpu_sequencer_if bus();

  cpu_sequencer dut (
    .clk(clk), .rst(rst), .run(run), .bus(bus),
    .busy(busy), .halted(halted), .illegal(illegal), .retired(retired)
  );

  always #5 clk = ~clk;

  stim_t sq[$];
  outs_t eq[$];
  int    tq[$];
  int    model_ret;
  bit    model_idle;
  int    i_dec, i_mem, i_exec, i_last;
  int    checks = 0, errors = 0;
  int    cur = 0;
  bit    active = 0;

  function automatic bit rb();
    return 1'($urandom);
  endfunction

  task automatic add_cyc(input bit r, input logic [7:0] irv, input bit ack,
                         input outs_t e, input bit ret_now);
    stim_t s;
    s.rst = 1'b1; s.run = r; s.ir = irv; s.ack = ack;
    e.retired = model_ret[7:0];
    sq.push_back(s); eq.push_back(e); tq.push_back(0);
    if (ret_now) model_ret = (model_ret + 1) % 256;
  endtask

  task automatic do_reset(input int n);
    stim_t s;
    outs_t e;
    for (int k = 0; k < n; k++) begin
      s.rst = 1'b0; s.run = rb(); s.ir = 8'($urandom); s.ack = rb();
      e = '0;
      sq.push_back(s); eq.push_back(e); tq.push_back(0);
    end
    model_ret  = 0;
    model_idle = 1;
  endtask

  task automatic idle(input int n);
    outs_t e;
    for (int k = 0; k < n; k++) begin
      e = '0;
      add_cyc(1'b0, 8'($urandom), rb(), e, 1'b0);
    end
  endtask

  task automatic halt_cycles(input int n);
    outs_t e;
    for (int k = 0; k < n; k++) begin
      e = '0; e.halted = 1'b1;
      add_cyc(1'b1, 8'($urandom), rb(), e, 1'b0);
    end
  endtask

  // One instruction as the programmer sees it: fetch, decode, optional
  // memory phase of waitn stall cycles plus the ack cycle, then execute.
  task automatic instr(input logic [7:0] irv, input int waitn,
                       input bit run_next, input bit abort);
    logic [3:0] op;
    logic [1:0] rg;
    outs_t      e;
    bit         is_mem;
    op = irv[7:4];
    rg = irv[1:0];
    is_mem = (op == 4'd1 || op == 4'd2 || op == 4'd7);
    if (model_idle) begin
      e = '0;
      add_cyc(1'b1, irv, rb(), e, 1'b0);
      model_idle = 0;
    end
    e = '0; e.busy = 1; e.read_rom = 1; e.load_ir = 1; e.inc_pc = 1;
    add_cyc(rb(), irv, rb(), e, 1'b0);
    i_dec = sq.size();
    e = '0; e.busy = 1;
    if (op == 4'd0 || op > 4'd8) begin
      e.illegal = (op > 4'd8);
      add_cyc(run_next, irv, rb(), e, 1'b1);
      model_idle = !run_next;
      i_last = i_dec;
      return;
    end
    if (op == 4'd8) begin
      add_cyc(rb(), irv, rb(), e, 1'b0);
      i_last = i_dec;
      return;
    end
    e.load_mar = is_mem;
    add_cyc(rb(), irv, rb(), e, 1'b0);
    if (is_mem) begin
      i_mem = sq.size();
      e = '0; e.busy = 1;
      if (op == 4'd2) e.write_ram = 1; else e.read_ram = 1;
      for (int k = 0; k < waitn; k++) add_cyc(rb(), irv, 1'b0, e, 1'b0);
      if (abort) return;
      if (op == 4'd2) begin
        add_cyc(run_next, irv, 1'b1, e, 1'b1);
        model_idle = !run_next;
        i_last = sq.size() - 1;
        return;
      end
      e.load_mbr = 1;
      add_cyc(rb(), irv, 1'b1, e, 1'b0);
    end
    i_exec = sq.size();
    e = '0; e.busy = 1;
    case (op)
      4'd1: begin e.load_acc = 1; e.u8 = 1; e.u9 = 2'd1; end
      4'd7: begin e.load_acc = 1; e.u8 = 1; e.u9 = 2'd2; end
      4'd3: begin e.load_acc = 1; e.u7 = rg; end
      4'd4: e.load_reg[rg] = 1'b1;
      4'd5, 4'd6: begin
        e.load_acc = 1; e.u7 = rg; e.u9 = 2'd2; e.alu_sel = (op == 4'd6);
      end
      default: ;
    endcase
    add_cyc(run_next, irv, rb(), e, 1'b1);
    model_idle = !run_next;
    i_last = i_exec;
  endtask

  task automatic chk(input bit ok, input string nm, input int act, input int req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0d expected=%0d", nm, cur, act, req);
    end
  endtask

  // Per-cycle compare against the trace plus tagged literal checks.
  initial begin
    outs_t act;
    int    rd_cnt, wr_cnt, mbr_cnt, acc_cnt, hlt_cnt, tag;
    rd_cnt = 0; wr_cnt = 0; mbr_cnt = 0; acc_cnt = 0; hlt_cnt = 0;
    forever begin
      @(negedge clk);
      if (active) begin
        act = '{bus.read_rom, bus.inc_pc, bus.load_ir, bus.load_mar,
                bus.read_ram, bus.write_ram, bus.load_mbr, bus.load_acc,
                {bus.load_reg_d, bus.load_reg_c, bus.load_reg_b, bus.load_reg_a},
                bus.alu_sel, bus.mux_sel_u7, bus.mux_sel_u8, bus.mux_sel_u9,
                busy, halted, illegal, retired};
        checks++;
        if (act !== eq[cur]) begin
          errors++;
          $display("FAIL trace cyc=%0d got=%h expected=%h", cur, act, eq[cur]);
        end
        chk($countones(act.load_reg) <= 1 && !(act.read_ram && act.write_ram),
            "exclusive", int'(act.load_reg), 0);
        tag = tq[cur];
        if (tag == 3 || tag == 5 || tag == 10) begin
          rd_cnt = 0; wr_cnt = 0; mbr_cnt = 0; acc_cnt = 0; hlt_cnt = 0;
        end
        rd_cnt  += int'(act.read_ram);
        wr_cnt  += int'(act.write_ram);
        mbr_cnt += int'(act.load_mbr);
        acc_cnt += int'(act.load_acc);
        hlt_cnt += int'(act.halted && !act.busy);
        case (tag)
          1: chk(act.load_acc && act.u7 == 2 && act.u9 == 2 && !act.alu_sel && !act.u8,
                 "add_c_exec", int'({act.load_acc, act.u7, act.u9, act.alu_sel}), 'b1_10_10_0);
          2: chk(act.retired == 1, "add_c_retired", int'(act.retired), 1);
          4: begin
            chk(rd_cnt == 5, "lda_read_ram_cycles", rd_cnt, 5);
            chk(mbr_cnt == 1, "lda_load_mbr_cycles", mbr_cnt, 1);
            chk(act.u9 == 1 && act.u8 && act.load_acc, "lda_exec_u9", int'(act.u9), 1);
          end
          6: begin
            chk(wr_cnt == 2, "sta_write_ram_cycles", wr_cnt, 2);
            chk(acc_cnt == 0, "sta_no_load_acc", acc_cnt, 0);
            chk(act.read_rom == 1, "sta_then_fetch", int'(act.read_rom), 1);
          end
          7: chk(act.load_reg == 4'b1000 && !act.load_acc, "mova_d", int'(act.load_reg), 8);
          8: chk(act.illegal == 1, "illegal_pulse", int'(act.illegal), 1);
          9: chk(act.illegal == 0 && act.read_rom == 1, "illegal_then_fetch",
                 int'({act.illegal, act.read_rom}), 1);
          11: chk(hlt_cnt == 20, "halt_held", hlt_cnt, 20);
          12: begin
            chk(act.retired == 0, "halt_reset_retired", int'(act.retired), 0);
            chk(!act.halted && !act.busy, "halt_reset_idle", int'({act.halted, act.busy}), 0);
          end
          13: chk(act.retired == 0, "nop_wrap", int'(act.retired), 0);
          14: chk(act.retired == 255, "nop_255", int'(act.retired), 255);
          15: chk(act == '0, "reset_in_memrd", int'(act[28:8]), 0);
          default: ;
        endcase
      end
    end
  end

  initial begin
    int a_exec, l_mem, l_exec, s_mem, s_last, m_exec, il_dec, h0, h1, r0, n_dec, x0;
    stim_t s;
    bus.ir = 8'h00; bus.mem_ack = 1'b0;
    model_ret = 0; model_idle = 1;

    do_reset(2);
    instr(8'h52, 0, 1'b1, 1'b0); a_exec = i_exec;
    instr(8'h10, 4, 1'b1, 1'b0); l_mem = i_mem; l_exec = i_exec;
    instr(8'h20, 1, 1'b1, 1'b0); s_mem = i_mem; s_last = i_last;
    instr(8'h43, 0, 1'b1, 1'b0); m_exec = i_exec;
    instr(8'hA0, 0, 1'b1, 1'b0); il_dec = i_dec;
    instr(8'h80, 0, 1'b1, 1'b0);
    h0 = sq.size(); halt_cycles(20); h1 = sq.size() - 1;
    r0 = sq.size(); do_reset(2);
    idle(3);
    for (int k = 0; k < 256; k++) instr({4'd0, 4'($urandom)}, 0, 1'b1, 1'b0);
    n_dec = i_dec;
    for (int k = 0; k < 300; k++) begin
      int  op;
      bit  rn;
      op = $urandom_range(0, 14);
      if (op >= 8) op++;
      rn = ($urandom_range(0, 3) != 0);
      instr({4'(op), 4'($urandom)}, $urandom_range(0, 3), rn, 1'b0);
      if (!rn) idle($urandom_range(0, 2));
    end
    instr(8'h10, 2, 1'b1, 1'b1);
    x0 = sq.size(); do_reset(2);
    idle(2);

    tq[a_exec] = 1;  tq[a_exec + 1] = 2;
    tq[l_mem] = 3;   tq[l_exec] = 4;
    tq[s_mem] = 5;   tq[s_last + 1] = 6;
    tq[m_exec] = 7;
    tq[il_dec] = 8;  tq[il_dec + 1] = 9;
    tq[h0] = 10;     tq[h1] = 11;
    tq[r0] = 12;
    tq[n_dec] = 14;  tq[n_dec + 1] = 13;
    tq[x0] = 15;

    for (int i = 0; i < sq.size(); i++) begin
      @(posedge clk);
      #1;
      s = sq[i];
      rst = s.rst; run = s.run; bus.ir = s.ir; bus.mem_ack = s.ack;
      cur = i;
      active = 1;
    end
    @(posedge clk);
    #1 active = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
